dc_decode_controller: RTL and testbench

- Sequences the combinational DC Huffman table for one colour component, one bit per cycle.
- Owns the table's state register and walks the code tree to a size category (s).
- Shifts in s magnitude bits, sign-extends per JPEG rules and adds the DPCM predictor.
- Emits one signed DC coefficient per block; sits between the bitstream unstuffer and the dequantiser.

---
 rtl/dc_decode_controller.sv | 133 +++++++++++++
 tb/tb_dc_decode_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_decode_controller.sv
// DC coefficient decode sequencer: walks the external Huffman table one bit per cycle,
// collects s magnitude bits and emits a signed DC value. `DC_DPCM_PREDICT_EN adds the DPCM predictor.
module dc_decode_controller #(
    parameter int DC_W  = 12,
    parameter int MAX_S = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bit_in,
    input  logic            bit_valid,
    output logic            bit_ready,
    output logic            tbl_bit,
    output logic [3:0]      tbl_state,
    input  logic [3:0]      tbl_s_value,
    input  logic [3:0]      tbl_next_state,
    input  logic            pred_clear,
    output logic [DC_W-1:0] dc_out,
    output logic            dc_valid,
    input  logic            dc_ready,
    output logic            err,
    input  logic            err_clear
);

    typedef enum logic [1:0] {CODE, MAG, OUT, ERR} state_t;

    localparam logic [3:0] MAX_S_L = 4'(MAX_S);
    localparam logic [3:0] ST_LAST = 4'd11;  // eight 1s seen; a ninth 1 is not a legal code

    state_t            fsm_q;
    logic [3:0]        tbl_state_q, s_reg_q, cnt_q;
    logic [MAX_S-2:0]  mag_q;
    logic [MAX_S-1:0]  mag_d;
    logic [DC_W-1:0]   dc_out_q, mag_ext, half, mask, diff_d, base_d, result_d;
    logic              dc_valid_q, err_q, xfer, msb;

`ifdef DC_DPCM_PREDICT_EN
    logic [DC_W-1:0]   pred_q;
    assign base_d = pred_q;
`else
    logic              unused_pred_clear;
    assign unused_pred_clear = pred_clear;
    assign base_d = '0;
`endif

    assign bit_ready = (fsm_q == CODE) || (fsm_q == MAG);
    assign xfer      = bit_valid && bit_ready;
    assign tbl_bit   = bit_in;
    assign tbl_state = tbl_state_q;
    assign dc_out    = dc_out_q;
    assign dc_valid  = dc_valid_q;
    assign err       = err_q;

    // The first magnitude bit sits at position s-1; a 0 there marks a negative difference.
    always_comb begin
        mag_d    = {mag_q, bit_in};
        mag_ext  = DC_W'(mag_d);
        half     = DC_W'(1) << (s_reg_q - 4'd1);
        mask     = (half << 1) - DC_W'(1);
        msb      = |(mag_ext & half);
        diff_d   = msb ? mag_ext : mag_ext - mask;
        result_d = base_d + diff_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= CODE;
            tbl_state_q <= '0;
            mag_q       <= '0;
            s_reg_q     <= '0;
            cnt_q       <= '0;
            dc_out_q    <= '0;
            dc_valid_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef DC_DPCM_PREDICT_EN
            pred_q      <= '0;
`endif
        end else begin
            case (fsm_q)
                CODE: if (xfer) begin
                    if (tbl_state_q == ST_LAST && bit_in) begin
                        err_q       <= 1'b1;
                        tbl_state_q <= '0;
                        fsm_q       <= ERR;
                    end else if (tbl_next_state == 4'd0) begin
                        s_reg_q     <= tbl_s_value;
                        tbl_state_q <= '0;
                        if (tbl_s_value > MAX_S_L) begin
                            err_q <= 1'b1;
                            fsm_q <= ERR;
                        end else if (tbl_s_value == 4'd0) begin
                            dc_out_q   <= base_d;
                            dc_valid_q <= 1'b1;
                            fsm_q      <= OUT;
                        end else begin
                            cnt_q <= '0;
                            mag_q <= '0;
                            fsm_q <= MAG;
                        end
                    end else begin
                        tbl_state_q <= tbl_next_state;
                    end
                end
                MAG: if (xfer) begin
                    mag_q <= mag_d[MAX_S-2:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == s_reg_q - 4'd1) begin
                        dc_out_q   <= result_d;
                        dc_valid_q <= 1'b1;
                        fsm_q      <= OUT;
`ifdef DC_DPCM_PREDICT_EN
                        pred_q     <= result_d;
`endif
                    end
                end
                OUT: if (dc_ready) begin
                    dc_valid_q <= 1'b0;
                    fsm_q      <= CODE;
                end
                ERR: if (err_clear) begin
                    err_q       <= 1'b0;
                    tbl_state_q <= '0;
                    fsm_q       <= CODE;
                end
                default: fsm_q <= CODE;
            endcase
`ifdef DC_DPCM_PREDICT_EN
            // Clear overrides a same-cycle predictor update; dc_out keeps the computed value.
            if (pred_clear) pred_q <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_dc_decode_controller.sv
// Randomized bench for dc_decode_controller: encodes DC differences with the JPEG luminance
// DC table and compares each decoded coefficient against an encoder-side reference model.
module tb_dc_decode_controller;

    localparam int DC_W = 12;
`ifdef DC_DPCM_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            bit_in = 1'b0, bit_valid = 1'b0, bit_ready, tbl_bit;
    logic [3:0]      tbl_state, tbl_s_value, tbl_next_state;
    logic            pred_clear = 1'b0, dc_ready = 1'b0, err_clear = 1'b0;
    logic [DC_W-1:0] dc_out;
    logic            dc_valid, err;
    logic            bad_s = 1'b0;

    int checks = 0, failures = 0;
    int ref_pred = 0;
    int gap_pct = 0;

    // JPEG luminance DC code words (value, length) indexed by size category.
    int code_v[12] = '{0, 2, 3, 4, 5, 6, 14, 30, 62, 126, 254, 510};
    int code_l[12] = '{2, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8, 9};

    always #5 clk = ~clk;

    dc_decode_controller #(.DC_W(DC_W), .MAX_S(11)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .tbl_bit(tbl_bit), .tbl_state(tbl_state), .tbl_s_value(tbl_s_value),
        .tbl_next_state(tbl_next_state), .pred_clear(pred_clear), .dc_out(dc_out),
        .dc_valid(dc_valid), .dc_ready(dc_ready), .err(err), .err_clear(err_clear)
    );

    // Combinational Huffman table environment for the luminance DC code.
    always_comb begin
        tbl_next_state = 4'd0;
        tbl_s_value    = 4'd0;
        case (tbl_state)
            4'd0: tbl_next_state = tbl_bit ? 4'd2 : 4'd1;
            4'd1: if (tbl_bit) tbl_next_state = 4'd3;
            4'd3: tbl_s_value = tbl_bit ? 4'd2 : 4'd1;
            4'd2: tbl_next_state = tbl_bit ? 4'd5 : 4'd4;
            4'd4: tbl_s_value = tbl_bit ? 4'd4 : 4'd3;
            4'd5: if (tbl_bit) tbl_next_state = 4'd6; else tbl_s_value = 4'd5;
            4'd6, 4'd7, 4'd8, 4'd9, 4'd10:
                if (tbl_bit) tbl_next_state = tbl_state + 4'd1; else tbl_s_value = tbl_state;
            4'd11: tbl_s_value = tbl_bit ? 4'd0 : 4'd11;
            default: ;
        endcase
        if (bad_s && tbl_next_state == 4'd0) tbl_s_value = 4'd13;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bit; optional idle gaps exercise bit_valid stalls.
    task automatic send_bit(input logic b, input logic pc);
        int n = 0;
        if ($urandom_range(0, 99) < gap_pct) begin
            bit_valid = 1'b0;
            bit_in = 1'($urandom);
            repeat ($urandom_range(1, 2)) tick();
        end
        bit_in = b;
        bit_valid = 1'b1;
        pred_clear = pc;
        while (!bit_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("bit_ready_wait", 32'(bit_ready), 32'd1);
        if (tbl_bit !== b) chk("tbl_bit", 32'(tbl_bit), 32'(b));
        tick();
        bit_valid = 1'b0;
        pred_clear = 1'b0;
    endtask

    // Encoder-side model: expected coefficient and predictor update.
    function automatic logic [DC_W-1:0] model(input int d, input bit pc);
        int v;
        v = PRED_EN ? ref_pred + d : d;
        v = v & ((1 << DC_W) - 1);
        ref_pred = pc ? 0 : v;
        return DC_W'(v);
    endfunction

    function automatic int mag_of(input int s, input int d);
        return (d >= 0) ? d : d + (1 << s) - 1;
    endfunction

    task automatic finish_block(input logic [DC_W-1:0] exp, input int rdy_wait);
        chk("dc_valid_lat", 32'(dc_valid), 32'd1);
        chk("dc_out", 32'(dc_out), 32'(exp));
        chk("bit_ready_out", 32'(bit_ready), 32'd0);
        for (int i = 0; i < rdy_wait; i++) begin
            tick();
            if (dc_out !== exp) chk("dc_out_hold", 32'(dc_out), 32'(exp));
            if (dc_valid !== 1'b1) chk("dc_valid_hold", 32'(dc_valid), 32'd1);
            if (bit_ready !== 1'b0) chk("bit_ready_hold", 32'(bit_ready), 32'd0);
        end
        dc_ready = 1'b1;
        tick();
        dc_ready = 1'b0;
        chk("dc_valid_drop", 32'(dc_valid), 32'd0);
        chk("bit_ready_back", 32'(bit_ready), 32'd1);
    endtask

    task automatic send_block(input int s, input int d, input bit pc, input int rdy_wait);
        int c, m;
        logic [DC_W-1:0] exp;
        c = code_v[s];
        m = mag_of(s, d);
        for (int i = code_l[s] - 1; i >= 0; i--)
            send_bit(c[i], (s == 0 && i == 0) ? pc : 1'b0);
        if (s > 0) begin
            if (tbl_state !== 4'd0) chk("tbl_state_done", 32'(tbl_state), 32'd0);
            for (int i = s - 1; i >= 0; i--) send_bit(m[i], (i == 0) ? pc : 1'b0);
        end
        exp = model(d, pc);
        finish_block(exp, rdy_wait);
    endtask

    function automatic int rand_diff(input int s);
        int a;
        if (s == 0) return 0;
        a = int'($urandom_range((1 << s) - 1, 1 << (s - 1)));
        return ($urandom_range(0, 1) == 1) ? a : -a;
    endfunction

    initial begin
        repeat (2) tick();
        chk("rst_tbl_state", 32'(tbl_state), 32'd0);
        chk("rst_dc_valid", 32'(dc_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_dc_out", 32'(dc_out), 32'd0);
        chk("idle_bit_ready", 32'(bit_ready), 32'd1);

        // s=0 block: dc_valid must rise only after the second code bit.
        send_bit(1'b0, 1'b0);
        chk("s0_first_bit", 32'(dc_valid), 32'd0);
        send_bit(1'b0, 1'b0);
        finish_block(model(0, 1'b0), 0);

        send_block(3, 5, 1'b0, 0);
        send_block(2, -2, 1'b0, 1);
        send_block(3, -5, 1'b0, 0);
        send_block(11, 2047, 1'b0, 0);
        send_block(11, -1024, 1'b0, 0);
        send_block(4, 9, 1'b0, 4);

        // Nine 1s: illegal code.
        for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0);
        chk("inv_err", 32'(err), 32'd1);
        chk("inv_bit_ready", 32'(bit_ready), 32'd0);
        chk("inv_tbl_state", 32'(tbl_state), 32'd0);
        bit_valid = 1'b1;
        repeat (2) tick();
        bit_valid = 1'b0;
        chk("err_sticky", 32'(err), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_bit_ready", 32'(bit_ready), 32'd1);
        chk("clr_tbl_state", 32'(tbl_state), 32'd0);
        send_block(1, 1, 1'b0, 0);

        // Size category beyond MAX_S from the table.
        bad_s = 1'b1;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        bad_s = 1'b0;
        chk("bad_s_err", 32'(err), 32'd1);
        chk("bad_s_valid", 32'(dc_valid), 32'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("bad_s_clr", 32'(err), 32'd0);

        // err_clear outside ERR does not disturb a code in progress.
        send_bit(1'b1, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("eclr_ign_state", 32'(tbl_state), 32'd2);
        chk("eclr_ign_ready", 32'(bit_ready), 32'd1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        finish_block(model(6, 1'b0), 0);

        // pred_clear on the final magnitude bit, then a +1 block.
        send_block(3, 7, 1'b1, 0);
        send_block(1, 1, 1'b0, 0);

        // Reset mid-MAG.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_dc_out", 32'(dc_out), 32'd0);
        chk("rst_mid_ready", 32'(bit_ready), 32'd1);
        chk("rst_mid_tbl", 32'(tbl_state), 32'd0);
        tick();
        rst = 1'b0;
        ref_pred = 0;
        send_block(5, -17, 1'b0, 0);

        // Randomized blocks with bit stalls, output backpressure and occasional clears.
        gap_pct = 25;
        for (int k = 0; k < 60; k++) begin
            int s;
            s = int'($urandom_range(0, 11));
            send_block(s, rand_diff(s), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=done");
        $fatal(1, "watchdog");
    end

endmodule
